// File: rtl/byte_word_pkg.sv
// rtl/byte_word_pkg.sv - shared widths and FIFO entry type for the byte-to-word packer
// Purpose: lane/byte/word widths and the packed word entry carried through the word FIFO.
// Ports: none (package).
package byte_word_pkg;

   localparam int BYTE_W = 8;
   localparam int LANES  = 4;
   localparam int WORD_W = 32;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [LANES-1:0]  keep;
      logic              last;
   } word_entry_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous first-word-fallthrough FIFO of packed word entries
// Purpose: buffers completed words; head shows the oldest entry straight from storage.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, wr_entry    write request and entry (caller never pushes when full without a pop)
//   pop               remove head (caller only pops when not empty)
//   full, empty       occupancy flags
//   head              oldest entry, valid while !empty
module word_fifo
   import byte_word_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  word_entry_t wr_entry,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output word_entry_t head
);

   localparam int AW = $clog2(DEPTH);

   word_entry_t   mem [DEPTH];
   // One extra pointer bit separates the full and empty cases when the indices match.
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // When full, push and pop may share a slot: the head is read before the edge overwrites it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream little-endian into 32-bit words with keep/last
// Purpose: assembles bytes into words, queues them, drops and counts words that find the FIFO full.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   din, din_en, din_last          byte stream input, no backpressure
//   dout, dout_keep, dout_last     head word, zero while the FIFO is empty
//   dout_valid, dout_ready         output handshake
//   ovf, drop_cnt                  sticky drop flag and saturating drop counter
module byte_word_packer
   import byte_word_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        din,
   input  logic              din_en,
   input  logic              din_last,
   output logic [31:0]       dout,
   output logic [3:0]        dout_keep,
   output logic              dout_last,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              ovf,
   output logic [DROP_W-1:0] drop_cnt
);

   logic [WORD_W-1:0] asm_data;
   logic [LANES-1:0]  asm_keep;
   logic [1:0]        lane;

   logic [WORD_W-1:0] next_data;
   logic [LANES-1:0]  next_keep;
   logic              close;
   logic              pop;
   logic              push;
   logic              drop;
   logic              full;
   logic              empty;
   word_entry_t       head;
   word_entry_t       wr_entry;

   always_comb begin
      next_data = asm_data;
      next_data[lane*BYTE_W +: BYTE_W] = din;
      next_keep = asm_keep | (4'b0001 << lane);
   end

   assign close    = din_en && ((lane == 2'd3) || din_last);
   assign pop      = !empty && dout_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
   assign push     = close && (!full || pop);
   assign drop     = close && full && !pop;
   assign wr_entry = '{data: next_data, keep: next_keep, last: din_last};

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_data <= '0;
         asm_keep <= '0;
         lane     <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (din_en) begin
            if (close) begin
               asm_data <= '0;
               asm_keep <= '0;
               lane     <= '0;
            end else begin
               asm_data <= next_data;
               asm_keep <= next_keep;
               lane     <= lane + 2'd1;
            end
         end
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

   // Storage is not reset, so the head is masked until something has been written.
   assign dout_valid = !empty;
   assign dout       = empty ? '0 : head.data;
   assign dout_keep  = empty ? '0 : head.keep;
   assign dout_last  = empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - scoreboard bench for byte_word_packer
module tb_byte_word_packer;

   localparam int DROP_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        din;
   logic              din_en;
   logic              din_last;
   logic [31:0]       dout;
   logic [3:0]        dout_keep;
   logic              dout_last;
   logic              dout_valid;
   logic              dout_ready;
   logic              ovf;
   logic [DROP_W-1:0] drop_cnt;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [36:0] sb[$];
   logic [36:0] held;
   logic        held_v = 1'b0;

   always #5 clk = ~clk;

   // A narrow drop counter lets saturation be reached in a handful of drops.
   byte_word_packer #(.FIFO_DEPTH(4), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_en     (din_en),
      .din_last   (din_last),
      .dout       (dout),
      .dout_keep  (dout_keep),
      .dout_last  (dout_last),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .ovf        (ovf),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      sb.push_back({d, k, l});
   endtask

   task automatic send(input logic [7:0] b, input logic l);
      din      = b;
      din_en   = 1'b1;
      din_last = l;
      @(posedge clk);
      #1;
      din_en   = 1'b0;
      din_last = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      dout_ready = 1'b1;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", 64'(sb.size()), 64'd0);
      chk("drain_valid_low", 64'(dout_valid), 64'd0);
   endtask

   // Monitor: compares every transferred word against the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         held_v <= 1'b0;
      end else begin
         if (held_v && dout_valid)
            chk("stall_stable", 64'({dout, dout_keep, dout_last}), 64'(held));
         if (dout_valid && dout_ready) begin
            if (sb.size() == 0) chk("unexpected_word", 64'({dout, dout_keep, dout_last}), 64'h1_ffff_ffff_f);
            else chk("word", 64'({dout, dout_keep, dout_last}), 64'(sb.pop_front()));
         end
         held_v <= dout_valid && !dout_ready;
         held   <= {dout, dout_keep, dout_last};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; din = '0; din_en = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(1);
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_dout", 64'({dout, dout_keep, dout_last}), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);

      // Full word, latency of one edge.
      dout_ready = 1'b1;
      expect_word(32'h44332211, 4'hF, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      chk("pre_close_valid", 64'(dout_valid), 64'd0);
      send(8'h44, 1'b0);
      chk("latency_valid", 64'(dout_valid), 64'd1);
      idle(1);
      chk("empty_gate", 64'({dout_valid, dout, dout_keep, dout_last}), 64'd0);

      // Short frames, lane restart, din_last without din_en ignored.
      expect_word(32'h0000BBAA, 4'h3, 1'b1);
      send(8'hAA, 1'b0); send(8'hBB, 1'b1);
      expect_word(32'h000000CC, 4'h1, 1'b1);
      send(8'hCC, 1'b1);
      din_last = 1'b1; din = 8'hEE;
      idle(1);
      din_last = 1'b0;
      expect_word(32'h04030201, 4'hF, 1'b0);
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
      idle(2);

      // Five words into a stalled four-deep FIFO: fifth is dropped.
      dout_ready = 1'b0;
      expect_word(32'h13121110, 4'hF, 1'b0);
      expect_word(32'h17161514, 4'hF, 1'b0);
      expect_word(32'h1B1A1918, 4'hF, 1'b0);
      expect_word(32'h1F1E1D1C, 4'hF, 1'b0);
      for (int i = 0; i < 20; i++) send(8'(8'h10 + i), 1'b0);
      chk("ovf_set", 64'(ovf), 64'd1);
      chk("drop_one", 64'(drop_cnt), 64'd1);
      chk("stalled_head", 64'({dout_valid, dout}), 64'h1_13121110);
      idle(3);
      drain();

      // Full FIFO, closing byte coincides with a pop: no drop.
      dout_ready = 1'b0;
      expect_word(32'h33323130, 4'hF, 1'b0);
      expect_word(32'h37363534, 4'hF, 1'b0);
      expect_word(32'h3B3A3938, 4'hF, 1'b0);
      expect_word(32'h3F3E3D3C, 4'hF, 1'b0);
      expect_word(32'h43424140, 4'hF, 1'b0);
      for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b0);
      send(8'h40, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
      dout_ready = 1'b1;
      send(8'h43, 1'b0);
      dout_ready = 1'b0;
      chk("coincide_no_drop", 64'(drop_cnt), 64'd1);
      send(8'h50, 1'b0); send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0);
      chk("still_full_drop", 64'(drop_cnt), 64'd2);
      drain();

      // Reset with three words buffered and a partial word.
      dout_ready = 1'b0;
      for (int i = 0; i < 14; i++) send(8'(8'h60 + i), 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("flush_valid", 64'(dout_valid), 64'd0);
      chk("flush_outputs", 64'({dout, dout_keep, dout_last}), 64'd0);
      chk("flush_ovf", 64'(ovf), 64'd0);
      chk("flush_drop", 64'(drop_cnt), 64'd0);
      dout_ready = 1'b1;
      expect_word(32'h04030201, 4'hF, 1'b0);
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
      drain();

      // Saturation of the drop counter.
      dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) expect_word(32'(8'h80 + i), 4'h1, 1'b1);
      for (int i = 0; i < 18; i++) send(8'(8'h80 + i), 1'b1);
      chk("drop_allones_m1", 64'(drop_cnt), 64'd14);
      for (int i = 0; i < 3; i++) send(8'hF0, 1'b1);
      chk("drop_saturated", 64'(drop_cnt), 64'd15);
      chk("ovf_sticky", 64'(ovf), 64'd1);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
